ddr3_port_arbiter: RTL and testbench
====================================

# ddr3_port_arbiter

Two-client arbiter that shares the single DDR3 MIG user-interface port between independent 128-bit burst requesters (e.g. frame-buffer scan-out and a sprite/CPU loader). It grants one client at a time and drives the MIG command, write-data and read-data paths for one full burst. Read data is returned to the owning client with a one-cycle valid pulse. One transaction is in flight at a time; the block sits directly between the client-side readers/writers and the MIG.

## Interface
- ADDR_W, 27, MIG address width (16-bit word address).
- BEAT_W, 64, MIG data beat width; burst = 2 beats = 128 bits.
- clk  in  1  system/MIG UI clock.
- reset  in  1  reset, synchronous, active-high.
- c_req  in  [1:0]  per-client request; held high until c_ack.
- c_we  in  [1:0]  1 = write burst, 0 = read burst; stable while c_req.
- c_addr  in  [1:0][ADDR_W-1:0]  burst address; bits [2:0] ignored (masked to 0).
- c_wdata  in  [1:0][127:0]  write burst; stable while c_req.
- c_ack  out  [1:0]  one-cycle pulse, transaction complete.
- c_rdata  out  128  read burst, valid only with c_ack of a read.
- ram_address  out  ADDR_W  MIG app_addr.
- ram_cmd  out  3  3'b001 read, 3'b000 write.
- ram_en  out  1  MIG app_en.
- ram_rdy  in  1  MIG app_rdy.
- ram_wdf_data  out  BEAT_W  write beat.
- ram_wdf_wren  out  1  write beat valid.
- ram_wdf_end  out  1  last write beat.
- ram_wdf_rdy  in  1  write FIFO ready.
- ram_rd_valid  in  1  read beat valid.
- ram_rd_data_end  in  1  last read beat.
- ram_rd_data  in  BEAT_W  read beat.

## Operation
- States: IDLE, WR_D0, WR_D1, WR_CMD, RD_CMD, RD_DATA, ACK.
- IDLE: if any c_req, pick winner (see arbitration), latch owner, we, addr & 27'h7FFFFF8; go WR_D0 if write else RD_CMD.
- WR_D0: wdf_wren=1, data=c_wdata[owner][127:64]; advance on ram_wdf_rdy. WR_D1: data=[63:0], wdf_end=1; advance on ram_wdf_rdy to WR_CMD.
- WR_CMD / RD_CMD: ram_en=1, ram_cmd per op, ram_address=latched addr; command accepted when ram_en & ram_rdy. WR_CMD -> ACK; RD_CMD -> RD_DATA.
- RD_DATA: beat with ram_rd_valid & !ram_rd_data_end -> c_rdata[127:64]; beat with ram_rd_valid & ram_rd_data_end -> c_rdata[63:0], go ACK.
- ACK: c_ack[owner]=1 for exactly one cycle; update last_grant=owner; return IDLE. Next grant earliest the following cycle.
- Arbitration: round-robin; single requester wins; both requesting -> client != last_grant.
- ram_rd_valid outside RD_DATA is ignored (stale data discarded). c_req drop before ack is a protocol error; transaction still completes, ack still pulses.
- c_rdata holds last read burst until overwritten.

## Timing
- Reset values: ram_en 0, ram_cmd 3'b000, ram_address 0, ram_wdf_wren 0, ram_wdf_end 0, ram_wdf_data 0, c_ack 0, c_rdata 0, state IDLE, last_grant 1 (client 0 wins first tie).
- Reset mid-transaction: abort next edge to IDLE, all outputs to reset values, no ack; MIG read data arriving later ignored.
- Write, ready always high: req cycle 0 -> WR_D0 1, WR_D1 2, WR_CMD 3, ACK 4 (ack 4 cycles after req seen).
- Read: RD_CMD the cycle after grant; ack the cycle after end beat.
- ram_en/ram_wdf_wren held asserted while rdy low (no drop, no data change).

## Configuration
- DDR_ARB_FIXED_PRIO_EN defined: client 0 always wins ties; last_grant unused.
- Undefined: round-robin as above.

## Structure
- Package ddr_arb_pkg: state enum, CMD_READ=3'b001, CMD_WRITE=3'b000, BURST_ADDR_MASK=27'h7FFFFF8.
- Sub-module ddr_rr_pick: combinational two-way pick from c_req and last_grant (honours macro).

## Test plan
- Client 0 read addr 0x0000013, MIG returns 0xAAAA…/0x5555… -> ram_address 0x0000010, cmd 001, c_ack[0] pulse, c_rdata = {0xAAAA…,0x5555…}.
- Client 1 write 0x0000020 data {0x1111…,0x2222…}, wdf_rdy low 3 cycles -> wren held, beats 0x1111… then 0x2222… with end, then write cmd, c_ack[1].
- Both request continuously, ready always high -> grants alternate 0,1,0,1; with DDR_ARB_FIXED_PRIO_EN -> client 0 only.
- ram_rdy low 5 cycles during RD_CMD -> ram_en held with constant address; exactly one command accepted.
- Reset asserted in RD_DATA after first beat -> outputs reset, no ack; late end beat ignored; next read completes correctly.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR3 two-client port arbiter.
// Opcodes match the MIG app_cmd encoding.
package ddr_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_D0   = 3'd1,
    WR_D1   = 3'd2,
    WR_CMD  = 3'd3,
    RD_CMD  = 3'd4,
    RD_DATA = 3'd5,
    ACK     = 3'd6
  } state_t;

  localparam logic [2:0]  CMD_READ        = 3'b001;
  localparam logic [2:0]  CMD_WRITE       = 3'b000;
  localparam logic [26:0] BURST_ADDR_MASK = 27'h7FFFFF8;

endpackage

// File: rtl/ddr_rr_pick.sv
// Two-way winner select for the DDR3 port arbiter.
// Define DDR_ARB_FIXED_PRIO_EN to make client 0 win every tie.
module ddr_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       pick
);

`ifdef DDR_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    pick = 1'b0;
    if (!req[0] && req[1])
      pick = 1'b1;
  end
`else
  always_comb begin
    pick = 1'b0;
    unique case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant;
      default: pick = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Shares one DDR3 MIG UI port between two 128-bit burst clients.
// Build option: DDR_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module ddr3_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W = 27,
  parameter int BEAT_W = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   c_req,
  input  logic [1:0]                   c_we,
  input  logic [1:0][ADDR_W-1:0]       c_addr,
  input  logic [1:0][2*BEAT_W-1:0]     c_wdata,
  output logic [1:0]                   c_ack,
  output logic [2*BEAT_W-1:0]          c_rdata,
  output logic [ADDR_W-1:0]            ram_address,
  output logic [2:0]                   ram_cmd,
  output logic                         ram_en,
  input  logic                         ram_rdy,
  output logic [BEAT_W-1:0]            ram_wdf_data,
  output logic                         ram_wdf_wren,
  output logic                         ram_wdf_end,
  input  logic                         ram_wdf_rdy,
  input  logic                         ram_rd_valid,
  input  logic                         ram_rd_data_end,
  input  logic [BEAT_W-1:0]            ram_rd_data
);

  localparam logic [ADDR_W-1:0] MASK =
    ADDR_W'(BURST_ADDR_MASK);

  state_t            state;
  logic              owner;
  logic              last_grant;
  logic              pick;
  logic [ADDR_W-1:0] addr_q;

  ddr_rr_pick u_pick (
    .req        (c_req),
    .last_grant (last_grant),
    .pick       (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      c_rdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|c_req) begin
            owner  <= pick;
            addr_q <= c_addr[pick] & MASK;
            state  <= c_we[pick] ? WR_D0 : RD_CMD;
          end
        end
        WR_D0:
          if (ram_wdf_rdy) state <= WR_D1;
        WR_D1:
          if (ram_wdf_rdy) state <= WR_CMD;
        WR_CMD:
          if (ram_rdy) state <= ACK;
        RD_CMD:
          if (ram_rdy) state <= RD_DATA;
        RD_DATA: begin
          if (ram_rd_valid) begin
            if (ram_rd_data_end) begin
              c_rdata[BEAT_W-1:0] <= ram_rd_data;
              state <= ACK;
            end else begin
              c_rdata[2*BEAT_W-1:BEAT_W] <= ram_rd_data;
            end
          end
        end
        ACK: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default:
          state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state so a reset edge clears them at once.
  always_comb begin
    ram_en       = 1'b0;
    ram_cmd      = CMD_WRITE;
    ram_wdf_wren = 1'b0;
    ram_wdf_end  = 1'b0;
    ram_wdf_data = '0;
    c_ack        = '0;
    unique case (1'b1)
      (state == WR_D0): begin
        ram_wdf_wren = 1'b1;
        ram_wdf_data = c_wdata[owner][2*BEAT_W-1:BEAT_W];
      end
      (state == WR_D1): begin
        ram_wdf_wren = 1'b1;
        ram_wdf_end  = 1'b1;
        ram_wdf_data = c_wdata[owner][BEAT_W-1:0];
      end
      (state == WR_CMD):
        ram_en = 1'b1;
      (state == RD_CMD): begin
        ram_en  = 1'b1;
        ram_cmd = CMD_READ;
      end
      (state == ACK):
        c_ack[owner] = 1'b1;
      default: ;
    endcase
  end

  assign ram_address = addr_q;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed self-checking bench for ddr3_port_arbiter.
// Honours DDR_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_ddr3_port_arbiter;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        c_req;
  logic [1:0]        c_we;
  logic [1:0][26:0]  c_addr;
  logic [1:0][127:0] c_wdata;
  logic [1:0]        c_ack;
  logic [127:0]      c_rdata;
  logic [26:0]       ram_address;
  logic [2:0]        ram_cmd;
  logic              ram_en;
  logic              ram_rdy;
  logic [63:0]       ram_wdf_data;
  logic              ram_wdf_wren;
  logic              ram_wdf_end;
  logic              ram_wdf_rdy;
  logic              ram_rd_valid;
  logic              ram_rd_data_end;
  logic [63:0]       ram_rd_data;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] PAT_A = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] PAT_5 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PAT_1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] PAT_2 = 64'h2222_2222_2222_2222;

  ddr3_port_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .c_req           (c_req),
    .c_we            (c_we),
    .c_addr          (c_addr),
    .c_wdata         (c_wdata),
    .c_ack           (c_ack),
    .c_rdata         (c_rdata),
    .ram_address     (ram_address),
    .ram_cmd         (ram_cmd),
    .ram_en          (ram_en),
    .ram_rdy         (ram_rdy),
    .ram_wdf_data    (ram_wdf_data),
    .ram_wdf_wren    (ram_wdf_wren),
    .ram_wdf_end     (ram_wdf_end),
    .ram_wdf_rdy     (ram_wdf_rdy),
    .ram_rd_valid    (ram_rd_valid),
    .ram_rd_data_end (ram_rd_data_end),
    .ram_rd_data     (ram_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".en"},    ram_en,       1'b0);
    check({tag, ".cmd"},   ram_cmd,      3'b000);
    check({tag, ".addr"},  ram_address,  27'h0);
    check({tag, ".wren"},  ram_wdf_wren, 1'b0);
    check({tag, ".end"},   ram_wdf_end,  1'b0);
    check({tag, ".wdata"}, ram_wdf_data, 64'h0);
    check({tag, ".ack"},   c_ack,        2'b00);
    check({tag, ".rdata"}, c_rdata,      128'h0);
  endtask

  // Two read beats, end beat last; ack follows the end beat.
  task automatic read_beats(input logic [63:0] hi,
                            input logic [63:0] lo);
    ram_rd_valid    = 1'b1;
    ram_rd_data_end = 1'b0;
    ram_rd_data     = hi;
    tick();
    ram_rd_data_end = 1'b1;
    ram_rd_data     = lo;
    tick();
    ram_rd_valid    = 1'b0;
    ram_rd_data_end = 1'b0;
  endtask

  logic [1:0] exp_ack [4];
  int accepts;

  initial begin
    reset           = 1'b1;
    c_req           = '0;
    c_we            = '0;
    c_addr          = '0;
    c_wdata         = '0;
    ram_rdy         = 1'b1;
    ram_wdf_rdy     = 1'b1;
    ram_rd_valid    = 1'b0;
    ram_rd_data_end = 1'b0;
    ram_rd_data     = '0;
    tick();
    tick();
    reset = 1'b0;
    check_idle_outputs("rst");

    // client 0 read, unaligned address
    c_req     = 2'b01;
    c_we      = 2'b00;
    c_addr[0] = 27'h0000013;
    tick();
    check("rd0.en",   ram_en,      1'b1);
    check("rd0.cmd",  ram_cmd,     3'b001);
    check("rd0.addr", ram_address, 27'h0000010);
    tick();
    check("rd0.en_off", ram_en, 1'b0);
    read_beats(PAT_A, PAT_5);
    check("rd0.ack",   c_ack,   2'b01);
    check("rd0.rdata", c_rdata, {PAT_A, PAT_5});
    c_req = 2'b00;
    tick();
    check("rd0.ack_once", c_ack,   2'b00);
    check("rd0.hold",     c_rdata, {PAT_A, PAT_5});

    // client 1 write with write FIFO stalled for 3 cycles
    c_req      = 2'b10;
    c_we       = 2'b10;
    c_addr[1]  = 27'h0000020;
    c_wdata[1] = {PAT_1, PAT_2};
    ram_wdf_rdy = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("wr1.stall_wren", ram_wdf_wren, 1'b1);
      check("wr1.stall_data", ram_wdf_data, PAT_1);
      check("wr1.stall_end",  ram_wdf_end,  1'b0);
      tick();
    end
    ram_wdf_rdy = 1'b1;
    check("wr1.d0", ram_wdf_data, PAT_1);
    tick();
    check("wr1.d1",     ram_wdf_data, PAT_2);
    check("wr1.d1_end", ram_wdf_end,  1'b1);
    tick();
    check("wr1.cmd_en",   ram_en,       1'b1);
    check("wr1.cmd",      ram_cmd,      3'b000);
    check("wr1.cmd_addr", ram_address,  27'h0000020);
    check("wr1.cmd_wren", ram_wdf_wren, 1'b0);
    tick();
    check("wr1.ack", c_ack, 2'b10);
    c_req = 2'b00;
    tick();

    // both clients requesting continuously; last grant was client 1
`ifdef DDR_ARB_FIXED_PRIO_EN
    exp_ack = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    c_we       = 2'b11;
    c_addr[0]  = 27'h0000100;
    c_wdata[0] = {PAT_5, PAT_A};
    c_req      = 2'b11;
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 20 && c_ack == 2'b00; k++)
        tick();
      check($sformatf("rr.grant%0d", n), c_ack, exp_ack[n]);
      if (n == 3)
        c_req = 2'b00;
      tick();
    end
    tick();

    // command held while ram_rdy is low
    c_req     = 2'b01;
    c_we      = 2'b00;
    c_addr[0] = 27'h0000048;
    ram_rdy   = 1'b0;
    accepts   = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("rdy.en_held",   ram_en,      1'b1);
      check("rdy.addr_held", ram_address, 27'h0000048);
      if (ram_en && ram_rdy) accepts++;
      tick();
    end
    ram_rdy = 1'b1;
    if (ram_en && ram_rdy) accepts++;
    tick();
    for (int i = 0; i < 2; i++) begin
      if (ram_en && ram_rdy) accepts++;
      tick();
    end
    check("rdy.accepts", accepts, 1);
    read_beats(PAT_2, PAT_1);
    check("rdy.ack",   c_ack,   2'b01);
    check("rdy.rdata", c_rdata, {PAT_2, PAT_1});
    c_req = 2'b00;
    tick();

    // reset during RD_DATA after the first beat
    c_req     = 2'b10;
    c_we      = 2'b00;
    c_addr[1] = 27'h0000030;
    tick();
    tick();
    ram_rd_valid = 1'b1;
    ram_rd_data  = PAT_1;
    tick();
    ram_rd_valid = 1'b0;
    reset = 1'b1;
    c_req = 2'b00;
    tick();
    reset = 1'b0;
    check_idle_outputs("mid_rst");
    ram_rd_valid    = 1'b1;
    ram_rd_data_end = 1'b1;
    ram_rd_data     = PAT_2;
    tick();
    ram_rd_valid    = 1'b0;
    ram_rd_data_end = 1'b0;
    check("late.ack",   c_ack,   2'b00);
    check("late.rdata", c_rdata, 128'h0);
    check("late.en",    ram_en,  1'b0);

    c_req     = 2'b10;
    c_addr[1] = 27'h000003F;
    tick();
    check("post.cmd",  ram_cmd,     3'b001);
    check("post.addr", ram_address, 27'h0000038);
    tick();
    read_beats(PAT_5, PAT_2);
    check("post.ack",   c_ack,   2'b10);
    check("post.rdata", c_rdata, {PAT_5, PAT_2});
    c_req = 2'b00;
    tick();
    check("post.idle", c_ack, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
